// File: rtl/action_phv_merge_if.sv
// Handshake and data bundle between the action-issue point, the metadata
// ALU, the PHV merge block and the next stage.
`timescale 1ns/1ps
interface action_phv_merge_if #(
  parameter int unsigned PHV_LEN  = 1124,
  parameter int unsigned META_LEN = 256
);
  logic [PHV_LEN-1:0]  phv_in;
  logic                phv_valid_in;
  logic                phv_ready_out;
  logic [META_LEN-1:0] comp_meta_data_in;
  logic                comp_meta_data_valid_in;
  logic [PHV_LEN-1:0]  phv_out;
  logic                phv_valid_out;
  logic                phv_ready_in;
  logic [31:0]         drop_cnt_out;
  logic [1:0]          err_out;

  // Upstream / downstream environment side
  modport master (
    output phv_in, phv_valid_in, comp_meta_data_in, comp_meta_data_valid_in, phv_ready_in,
    input  phv_ready_out, phv_out, phv_valid_out, drop_cnt_out, err_out
  );

  // Merge block side
  modport slave (
    input  phv_in, phv_valid_in, comp_meta_data_in, comp_meta_data_valid_in, phv_ready_in,
    output phv_ready_out, phv_out, phv_valid_out, drop_cnt_out, err_out
  );
endinterface

// File: rtl/action_phv_merge.sv
// Buffers PHV bodies at action issue, pairs them in order with the modified
// metadata coming back from alu_3, splices the metadata into the low bits and
// forwards (or discards) the result over a valid/ready output register.
`timescale 1ns/1ps
module action_phv_merge #(
  parameter int unsigned PHV_LEN    = 1124,
  parameter int unsigned META_LEN   = 256,
  parameter int unsigned DEPTH_BITS = 2,
  parameter bit          DROP_EN    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  action_phv_merge_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << DEPTH_BITS;
  localparam int unsigned HI_LEN = PHV_LEN - META_LEN;

  typedef logic [DEPTH_BITS-1:0] ptr_t;
  typedef logic [DEPTH_BITS:0]   cnt_t;
  typedef logic [DEPTH_BITS+1:0] wide_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  out_state_t out_state, out_state_nxt;
  logic       load_out;

  logic [HI_LEN-1:0]   phv_mem  [DEPTH];
  logic [META_LEN-1:0] meta_mem [DEPTH];
  ptr_t phv_wr, phv_rd, meta_wr, meta_rd;
  cnt_t phv_cnt, meta_cnt;

  logic [HI_LEN-1:0]   phv_head;
  logic [META_LEN-1:0] meta_head;
  logic phv_full, meta_full, phv_push, meta_push, meta_ovf, meta_orphan;
  logic out_free, merge, drop;
  logic unused_low_bits;

  // Incoming metadata field of the PHV is replaced by the ALU result.
  assign unused_low_bits = ^bus.phv_in[META_LEN-1:0];

  assign phv_full  = (phv_cnt == cnt_t'(DEPTH));
  assign meta_full = (meta_cnt == cnt_t'(DEPTH));
  assign phv_head  = phv_mem[phv_rd];
  assign meta_head = meta_mem[meta_rd];

  assign phv_push  = bus.phv_valid_in & ~phv_full;
  assign out_free  = (out_state == OUT_EMPTY) | ((out_state == OUT_FULL) & bus.phv_ready_in);
  assign merge     = (phv_cnt != '0) & (meta_cnt != '0) & out_free;
  assign drop      = DROP_EN & meta_head[128];

  // A full meta FIFO still accepts when its head leaves this cycle (the write
  // lands on the slot being read, which is read before the edge).
  assign meta_push   = bus.comp_meta_data_valid_in & (~meta_full | merge);
  assign meta_ovf    = bus.comp_meta_data_valid_in & meta_full & ~merge;
  // Both FIFOs pop together on a merge, so pre-pop counts compare correctly.
  assign meta_orphan = meta_push &
                       ((wide_t'(meta_cnt) + wide_t'(1)) > (wide_t'(phv_cnt) + wide_t'(phv_push)));

  assign bus.phv_ready_out = ~phv_full;
  assign bus.phv_valid_out = (out_state == OUT_FULL);

  // FIFO storage, no reset needed: validity is tracked by the counts.
  always_ff @(posedge clk) begin
    if (phv_push)  phv_mem[phv_wr]   <= bus.phv_in[PHV_LEN-1:META_LEN];
    if (meta_push) meta_mem[meta_wr] <= bus.comp_meta_data_in;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_wr   <= '0;
      phv_rd   <= '0;
      meta_wr  <= '0;
      meta_rd  <= '0;
      phv_cnt  <= '0;
      meta_cnt <= '0;
    end else begin
      if (phv_push)  phv_wr  <= phv_wr + ptr_t'(1);
      if (meta_push) meta_wr <= meta_wr + ptr_t'(1);
      if (merge) begin
        phv_rd  <= phv_rd + ptr_t'(1);
        meta_rd <= meta_rd + ptr_t'(1);
      end
      phv_cnt  <= phv_cnt + cnt_t'(phv_push) - cnt_t'(merge);
      meta_cnt <= meta_cnt + cnt_t'(meta_push) - cnt_t'(merge);
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_state <= OUT_EMPTY;
    else        out_state <= out_state_nxt;
  end

  // Next output state: a kept merge fills the register, an accepted word
  // with nothing to replace it (or replaced by a discard) empties it.
  always_comb begin
    out_state_nxt = out_state;
    load_out      = 1'b0;
    if (merge && !drop) begin
      out_state_nxt = OUT_FULL;
      load_out      = 1'b1;
    end else if ((out_state == OUT_FULL) && bus.phv_ready_in) begin
      out_state_nxt = OUT_EMPTY;
    end
  end

  // Output data, discard counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.phv_out      <= '0;
      bus.drop_cnt_out <= '0;
      bus.err_out      <= '0;
    end else begin
      if (load_out) bus.phv_out <= {phv_head, meta_head};
      if (merge && drop && (bus.drop_cnt_out != '1))
        bus.drop_cnt_out <= bus.drop_cnt_out + 32'd1;
      bus.err_out <= bus.err_out | {meta_orphan, meta_ovf};
    end
  end
endmodule

// File: doc/action_phv_merge.md
Name: action_phv_merge

Overview:
- Sits directly downstream of the metadata ALU (alu_3) in each RMT stage's action engine.
- Buffers the PHV body captured when the action is issued. Waits for the ALU's modified metadata, which arrives a fixed number of cycles later, and splices that metadata into the low META_LEN bits of the buffered PHV.
- Honours the discard flag (metadata bit 128) and hands the merged PHV to the next stage over a valid/ready handshake.

Parameters:
- PHV_LEN, 1124, full PHV width; metadata occupies bits [META_LEN-1:0].
- META_LEN, 256, metadata width; must equal the ALU's META_LEN.
- DEPTH_BITS, 2, log2 of each internal FIFO depth (default depth 4).
- DROP_EN, 1, 1: PHVs with meta bit 128 set are discarded; 0: forwarded unchanged.

Ports:
- clk  input  1  stage clock.
- rst_n  input  1  reset, asynchronous, active-low.
- phv_in  input  PHV_LEN  PHV from the stage's action-issue point.
- phv_valid_in  input  1  phv_in valid; accepted only when phv_ready_out=1.
- phv_ready_out  output  1  PHV FIFO not full.
- comp_meta_data_in  input  META_LEN  modified metadata from alu_3.
- comp_meta_data_valid_in  input  1  single-cycle pulse; no backpressure possible.
- phv_out  output  PHV_LEN  merged PHV to the next stage.
- phv_valid_out  output  1  phv_out valid; held until accepted.
- phv_ready_in  input  1  downstream ready.
- drop_cnt_out  output  32  count of discarded PHVs, saturating at 0xFFFFFFFF.
- err_out  output  2  sticky; bit0 = metadata overflow, bit1 = orphan metadata.

Behaviour:
- Reset (async, rst_n=0):
  - Both FIFOs empty.
  - phv_out=0, phv_valid_out=0, drop_cnt_out=0, err_out=0.
  - phv_ready_out=1 once both FIFOs are empty.
  - Reset mid-operation discards all buffered entries; nothing is emitted afterwards for them.
- PHV FIFO:
  - Stores only phv_in[PHV_LEN-1:META_LEN]; the incoming low META_LEN bits are ignored.
  - Push when phv_valid_in & phv_ready_out.
  - phv_ready_out = !phv_full, combinational from the stored count.
  - A pop on the same cycle does not make room for a push when full.
- META FIFO:
  - Push on every comp_meta_data_valid_in.
  - If full and no pop this cycle: entry dropped, err_out[0] set.
  - If full and popping the same cycle: push accepted.
  - If the push would make meta count exceed PHV count, counting a same-cycle PHV push: err_out[1] set. The entry is still stored.
- Pointers and counts wrap modulo 2^DEPTH_BITS. Counts span 0..2^DEPTH_BITS.
- Output register state:
  - EMPTY: phv_valid_out=0.
  - FULL: phv_valid_out=1.
  - out_free = EMPTY | (FULL & phv_ready_in).
- Merge fires when both FIFOs are non-empty and out_free. On a merge:
  - Both FIFO heads are popped.
  - drop = DROP_EN & meta_head[128].
  - If !drop: phv_out <= {phv_head, meta_head} and the output register becomes FULL.
  - If drop: drop_cnt_out increments (saturating). The output register becomes EMPTY if it was being accepted this cycle, otherwise it stays unchanged.
- No merge while out_free: if FULL & phv_ready_in, the register becomes EMPTY and phv_valid_out drops the next cycle.
- While phv_valid_out=1 and phv_ready_in=0, phv_out is stable.
- Latency: metadata sampled at edge E → phv_valid_out=1 after edge E+1, provided the PHV FIFO is non-empty and out_free.
- Throughput: one merge per cycle when phv_ready_in stays high.
- Ordering: strictly in order; the i-th metadata pairs with the i-th PHV.
- Metadata is never modified; bit 128 is forwarded as-is when DROP_EN=0.

Test Plan:
- Single PHV, then meta after 5 cycles.
  - Stimulus: phv_in upper bits 0xAA.., meta=0x..01_00 (bit128=0).
  - Response: one cycle after the meta pulse, phv_valid_out=1 and phv_out={0xAA.., meta}.
- Discard, DROP_EN=1.
  - Stimulus: meta with bit128=1.
  - Response: no phv_valid_out; drop_cnt_out=1; FIFOs empty afterwards.
  - Repeat with DROP_EN=0: response is the PHV forwarded with bit128=1.
- Backpressure.
  - Stimulus: 4 PHVs and 4 metas with phv_ready_in=0.
  - Response: phv_out holds the first PHV; phv_ready_out=0 after the 4th PHV push.
  - Then raise phv_ready_in: 4 PHVs emitted in order on consecutive cycles.
- Overflow.
  - Stimulus: 4 PHVs pushed, downstream stalled, 6 meta pulses.
  - Response: err_out=2'b11 sticky.
  - Only the first 4 metas are used: one merge fills the output register, leaving meta count 3 with the 4-deep FIFO freeing a slot.
  - Check the exact drop count per the full/pop rule.
- Orphan.
  - Stimulus: meta pulse with the PHV FIFO empty.
  - Response: err_out[1]=1.
  - A later PHV merges with that stored meta one cycle after the PHV push.
- Reset mid-stream.
  - Stimulus: rst_n low for 1 cycle with 2 PHVs buffered and phv_valid_out=1.
  - Response: all outputs 0 immediately (async), no stale output afterwards, and phv_ready_out=1.
